uart_tx: RTL and testbench

Transmit half of the UART. Accepts bytes from the system clock domain through an 8-entry asynchronous FIFO and serialises each one on the bit-rate clock `tck` as an 11-bit frame: 1 start, 8 data LSB-first, 1 even-parity, 1 stop. Frames are bit-compatible with `uart_rx`, which sits on the far end of the line.

---
 rtl/uart_defs_pkg.sv | 38 +++
 rtl/uart_tx_fifo_async.sv | 124 ++++++++++++
 rtl/uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// ----------------------------------------------------------------------------
// uart_defs: shared types for the UART transmit/receive blocks.
//   Mode_t        : line mode (half- or full-duplex)
//   Config_t      : runtime configuration (mode, flush_tx)
//   TXState_t     : transmit frame state machine states
//   TXIrqFlags_t  : transmit interrupt/status flags (tck domain)
//   even_parity() : parity bit that makes data + parity carry an even weight
// ----------------------------------------------------------------------------
package uart_defs;

  typedef enum logic {
    HALFDUPLEX = 1'b0,
    FULLDUPLEX = 1'b1
  } Mode_t;

  typedef struct packed {
    Mode_t mode;
    logic  flush_tx;
  } Config_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_SHIFT  = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } TXState_t;

  typedef struct packed {
    logic frame_done;
    logic fifo_empty;
  } TXIrqFlags_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_async.sv
// ----------------------------------------------------------------------------
// fifo_async: dual-clock FIFO with Gray-coded pointers and 2-flop pointer
// synchronisers in each direction.
//   rst_n                    : asynchronous active-low reset, both domains
//   wr_clk_i                 : enqueue clock
//   enq_data_i / enq_valid_i : write data / write request
//   enq_ready_o              : space available (write domain)
//   full_o / empty_o         : occupancy as seen from the write domain
//   rd_clk_i                 : dequeue clock
//   deq_data_o / deq_valid_o : head entry / head valid (read domain)
//   deq_ready_i              : pop the head entry
//   flush_i                  : read-domain drop of every visible entry
// buffer_size must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module fifo_async #(
  parameter int unsigned data_size   = 8,
  parameter int unsigned buffer_size = 8
) (
  input  logic                 rst_n,
  // write side
  input  logic                 wr_clk_i,
  input  logic [data_size-1:0] enq_data_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  output logic                 full_o,
  output logic                 empty_o,
  // read side
  input  logic                 rd_clk_i,
  output logic [data_size-1:0] deq_data_o,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  input  logic                 flush_i
);

  localparam int unsigned AW = $clog2(buffer_size);
  localparam int unsigned PW = AW + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [data_size-1:0] mem_q [buffer_size];

  // write domain
  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q;
  logic [PW-1:0] rq1_q, rq2_q;
  logic [PW-1:0] rq_bin;
  logic          full;
  logic          enq;

  // read domain
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q;
  logic [PW-1:0] wq1_q, wq2_q;
  logic          empty_r;
  logic          deq;

  // ---------------- write side ----------------
  // Full when the pointers address the same slot but differ in the wrap bit.
  assign rq_bin   = gray2bin(rq2_q);
  assign full     = (wr_bin_q[AW] != rq_bin[AW]) &&
                    (wr_bin_q[AW-1:0] == rq_bin[AW-1:0]);
  assign enq      = enq_valid_i & ~full;
  assign wr_bin_d = wr_bin_q + PW'(enq);

  always_ff @(posedge wr_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rq1_q     <= '0;
      rq2_q     <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= bin2gray(wr_bin_d);
      rq1_q     <= rd_gray_q;
      rq2_q     <= rq1_q;
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (enq) begin
      mem_q[wr_bin_q[AW-1:0]] <= enq_data_i;
    end
  end

  assign enq_ready_o = ~full;
  assign full_o      = full;
  assign empty_o     = (wr_gray_q == rq2_q);

  // ---------------- read side ----------------
  // Flush jumps the read pointer to the synchronised write pointer, which
  // discards every entry the read side can currently see; the write side
  // observes the drain through the normal pointer synchroniser.
  assign empty_r     = (rd_gray_q == wq2_q);
  assign deq_valid_o = ~empty_r & ~flush_i;
  assign deq         = deq_valid_o & deq_ready_i;
  assign rd_bin_d    = flush_i ? gray2bin(wq2_q) : (rd_bin_q + PW'(deq));
  assign deq_data_o  = mem_q[rd_bin_q[AW-1:0]];

  always_ff @(posedge rd_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      wq1_q     <= '0;
      wq2_q     <= '0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= bin2gray(rd_bin_d);
      wq1_q     <= wr_gray_q;
      wq2_q     <= wq1_q;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx: transmit half of the UART. Bytes enter on clk through an async
// FIFO and are serialised on tck as 11-bit frames: start(0), 8 data bits
// LSB-first, even parity, stop(1).
//   clk / rst_n            : system clock (FIFO write side) / async reset
//   tck                    : bit-rate clock, one period per bit
//   tx_d_i / tx_d_valid_i  : byte to send / write request (clk domain)
//   tx_d_ready_o           : FIFO has space (clk domain)
//   tx_full_o / tx_empty_o : FIFO occupancy (clk domain)
//   tx_o                   : serial line, idles high, registered
//   tx_rts_n_o             : enabled and (data queued or frame in flight)
//   tx_cts_n_i             : peer ready, high = ready
//   tx_enable_i            : transmit enable for half-duplex
//   tx_busy_o              : frame in flight (tck domain)
//   tx_irq_flags_o         : frame_done pulse, fifo_empty level (tck domain)
//   uart_config_i          : mode and flush_tx
// ----------------------------------------------------------------------------
module uart_tx
  import uart_defs::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tck,
  input  logic [7:0]  tx_d_i,
  input  logic        tx_d_valid_i,
  output logic        tx_d_ready_o,
  output logic        tx_full_o,
  output logic        tx_empty_o,
  output logic        tx_o,
  output logic        tx_rts_n_o,
  input  logic        tx_cts_n_i,
  input  logic        tx_enable_i,
  output logic        tx_busy_o,
  output TXIrqFlags_t tx_irq_flags_o,
  input  Config_t     uart_config_i
);

  logic       en;
  logic       start_ok;

  logic       cts_meta_q, cts_ok_q;
  logic       flush_meta_q, flush_q;
  logic       empty_meta_q, empty_q;

  logic [7:0] deq_data;
  logic       deq_valid;
  logic       deq_ready;

  TXState_t   state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       frame_done_q, frame_done_d;

  assign en = (uart_config_i.mode == FULLDUPLEX) | tx_enable_i;

  fifo_async #(
    .data_size   (8),
    .buffer_size (FIFO_DEPTH)
  ) u_fifo (
    .rst_n       (rst_n),
    .wr_clk_i    (clk),
    .enq_data_i  (tx_d_i),
    .enq_valid_i (tx_d_valid_i),
    .enq_ready_o (tx_d_ready_o),
    .full_o      (tx_full_o),
    .empty_o     (tx_empty_o),
    .rd_clk_i    (tck),
    .deq_data_o  (deq_data),
    .deq_valid_o (deq_valid),
    .deq_ready_i (deq_ready),
    .flush_i     (flush_q)
  );

  // cts, flush and the write-side empty level are all foreign to tck.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q   <= 1'b0;
      cts_ok_q     <= 1'b0;
      flush_meta_q <= 1'b0;
      flush_q      <= 1'b0;
      empty_meta_q <= 1'b1;
      empty_q      <= 1'b1;
    end else begin
      cts_meta_q   <= tx_cts_n_i;
      cts_ok_q     <= cts_meta_q;
      flush_meta_q <= uart_config_i.flush_tx;
      flush_q      <= flush_meta_q;
      empty_meta_q <= tx_empty_o;
      empty_q      <= empty_meta_q;
    end
  end

  // en and cts only gate the start of a frame; a frame in flight always
  // runs to its stop bit.
  assign start_ok = en & cts_ok_q & deq_valid;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    deq_ready = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (start_ok) begin
          deq_ready = 1'b1;
          shift_d   = deq_data;
          par_d     = even_parity(deq_data);
          cnt_d     = 8'h01;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        // one-hot bit counter: bit 7 set marks the eighth data bit
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q << 1;
        if (cnt_q[7]) begin
          state_d = TX_PARITY;
        end
      end
      TX_PARITY: begin
        state_d = TX_STOP;
      end
      TX_STOP: begin
        if (start_ok) begin
          deq_ready = 1'b1;
          shift_d   = deq_data;
          par_d     = even_parity(deq_data);
          cnt_d     = 8'h01;
          state_d   = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so the flop presents each
  // bit for exactly the tck period that state occupies.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_SHIFT:  tx_d = shift_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign frame_done_d = (state_d == TX_STOP);

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_busy_o  = (state_q != TX_IDLE);
  assign tx_rts_n_o = en & (deq_valid | tx_busy_o);

  assign tx_irq_flags_o.frame_done = frame_done_q;
  assign tx_irq_flags_o.fifo_empty = empty_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  import uart_defs::*;

  logic        clk = 1'b0;
  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_d_i = '0;
  logic        tx_d_valid_i = 1'b0;
  logic        tx_d_ready_o;
  logic        tx_full_o;
  logic        tx_empty_o;
  logic        tx_o;
  logic        tx_rts_n_o;
  logic        tx_cts_n_i = 1'b1;
  logic        tx_enable_i = 1'b0;
  logic        tx_busy_o;
  TXIrqFlags_t irq;
  Config_t     cfg;

  always #5 clk = ~clk;
  initial forever #40 tck = ~tck;

  uart_tx #(.FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tck            (tck),
    .tx_d_i         (tx_d_i),
    .tx_d_valid_i   (tx_d_valid_i),
    .tx_d_ready_o   (tx_d_ready_o),
    .tx_full_o      (tx_full_o),
    .tx_empty_o     (tx_empty_o),
    .tx_o           (tx_o),
    .tx_rts_n_o     (tx_rts_n_o),
    .tx_cts_n_i     (tx_cts_n_i),
    .tx_enable_i    (tx_enable_i),
    .tx_busy_o      (tx_busy_o),
    .tx_irq_flags_o (irq),
    .uart_config_i  (cfg)
  );

  int          vectors = 0;
  int          miscompares = 0;

  // line monitor: frames captured bit i = i-th sampled bit time
  logic [10:0] frames[$];
  int unsigned fstart[$];
  int unsigned tcount = 0;
  int unsigned fd_count = 0;
  logic [7:0]  model_q[$];
  bit          mon_in = 0;
  int unsigned mon_idx = 0;
  logic [10:0] mon_cur = '0;

  // Reference frame built from the line format: start 0, data LSB first,
  // parity making the count of ones even, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int unsigned ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (b / (1 << i)) % 2;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((b / (1 << i)) % 2) != 0;
    f[9] = (ones % 2) != 0;
    f[10] = 1'b1;
    return f;
  endfunction

  initial begin
    forever begin
      @(negedge tck);
      tcount++;
      if (!rst_n) begin
        mon_in = 0;
      end else begin
        if (irq.frame_done === 1'b1) fd_count++;
        if (mon_in) begin
          mon_cur[mon_idx] = tx_o;
          mon_idx++;
          if (mon_idx == 11) begin
            frames.push_back(mon_cur);
            mon_in = 0;
          end
        end else if (tx_o === 1'b0) begin
          mon_in = 1;
          mon_cur = '0;
          mon_idx = 1;
          fstart.push_back(tcount);
        end
      end
    end
  end

  task automatic tck_wait(input int unsigned n);
    repeat (n) @(negedge tck);
    #1;
  endtask

  task automatic wait_frames(input int unsigned n, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (frames.size() < n && t < budget) begin
      tck_wait(1);
      t++;
    end
  endtask

  task automatic wait_busy(input int unsigned budget);
    int unsigned t;
    t = 0;
    while (tx_busy_o !== 1'b1 && t < budget) begin
      tck_wait(1);
      t++;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output bit accepted);
    @(negedge clk);
    tx_d_i = b;
    tx_d_valid_i = 1'b1;
    accepted = (tx_d_ready_o === 1'b1);
    @(negedge clk);
    tx_d_valid_i = 1'b0;
    if (accepted) model_q.push_back(b);
  endtask

  task automatic clear_queues();
    frames.delete();
    fstart.delete();
    model_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tck_wait(2);
    rst_n = 1'b1;
    tck_wait(2);
    clear_queues();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL reset_tx_o got=%b exp=1", tx_o); end
    vectors++; if (tx_busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", tx_busy_o); end
    vectors++; if (tx_rts_n_o !== 1'b0) begin miscompares++; $display("FAIL reset_rts got=%b exp=0", tx_rts_n_o); end
    vectors++; if (tx_d_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", tx_d_ready_o); end
    vectors++; if (tx_empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", tx_empty_o); end
    vectors++; if (tx_full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", tx_full_o); end
    vectors++; if (irq.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got=%b exp=0", irq.frame_done); end
    vectors++; if (irq.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_fifo_empty got=%b exp=1", irq.fifo_empty); end
  endtask

  task automatic test_single_frame();
    bit          acc;
    int unsigned fd0;
    logic [10:0] got, exp, a5_line;
    a5_line = 11'b10101001010;
    clear_queues();
    fd0 = fd_count;
    write_byte(8'hA5, acc);
    wait_frames(1, 40);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++; $display("FAIL single_count got=%0d exp=1", frames.size());
    end else begin
      got = frames.pop_front();
      exp = model_frame(model_q.pop_front());
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL single_frame got=%b exp=%b", got, exp); end
      vectors++; if (got !== a5_line) begin miscompares++; $display("FAIL single_a5_line got=%b exp=%b", got, a5_line); end
    end
    tck_wait(6);
    vectors++; if (fd_count - fd0 != 1) begin miscompares++; $display("FAIL single_frame_done got=%0d exp=1", fd_count - fd0); end
    vectors++; if (tx_busy_o !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy got=%b exp=0", tx_busy_o); end
    vectors++; if (irq.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL single_fifo_empty got=%b exp=1", irq.fifo_empty); end
  endtask

  task automatic test_parity();
    bit          acc;
    logic [10:0] got, exp;
    logic [7:0]  pat [2];
    logic        pbit [2];
    pat[0] = 8'h07; pbit[0] = 1'b1;
    pat[1] = 8'h00; pbit[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clear_queues();
      write_byte(pat[k], acc);
      wait_frames(1, 40);
      vectors++;
      if (frames.size() != 1) begin
        miscompares++; $display("FAIL parity_count byte=%h got=%0d exp=1", pat[k], frames.size());
      end else begin
        got = frames.pop_front();
        exp = model_frame(model_q.pop_front());
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL parity_frame got=%b exp=%b", got, exp); end
        vectors++; if (got[9] !== pbit[k]) begin miscompares++; $display("FAIL parity_bit byte=%h got=%b exp=%b", pat[k], got[9], pbit[k]); end
      end
      tck_wait(4);
    end
  endtask

  task automatic test_back_to_back();
    bit          acc;
    logic [10:0] got, exp;
    int unsigned s0, s1;
    tx_cts_n_i = 1'b0;
    tck_wait(4);
    clear_queues();
    for (int i = 0; i < 8; i++) write_byte(8'(i), acc);
    vectors++; if (tx_full_o !== 1'b1) begin miscompares++; $display("FAIL b2b_full got=%b exp=1", tx_full_o); end
    vectors++; if (tx_d_ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_ready got=%b exp=0", tx_d_ready_o); end
    write_byte(8'h55, acc);
    vectors++; if (acc !== 1'b0) begin miscompares++; $display("FAIL b2b_write_when_full got=%b exp=0", acc); end
    tx_cts_n_i = 1'b1;
    wait_frames(8, 8 * 11 + 40);
    vectors++;
    if (frames.size() != 8) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=8", frames.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        got = frames.pop_front();
        exp = model_frame(model_q.pop_front());
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL b2b_frame%0d got=%b exp=%b", i, got, exp); end
      end
      s0 = fstart.pop_front();
      for (int i = 0; i < 7; i++) begin
        s1 = fstart.pop_front();
        vectors++; if (s1 - s0 != 11) begin miscompares++; $display("FAIL b2b_spacing%0d got=%0d exp=11", i, s1 - s0); end
        s0 = s1;
      end
    end
    tck_wait(5);
    vectors++; if (tx_empty_o !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got=%b exp=1", tx_empty_o); end
  endtask

  task automatic test_flow_control();
    bit          acc;
    logic [10:0] got, exp;
    int unsigned t0, t;
    tx_cts_n_i = 1'b0;
    tck_wait(4);
    clear_queues();
    write_byte(8'($urandom), acc);
    write_byte(8'($urandom), acc);
    tck_wait(20);
    vectors++; if (frames.size() != 0 || fstart.size() != 0) begin miscompares++; $display("FAIL flow_hold got=%0d frames exp=0", fstart.size()); end
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL flow_line_idle got=%b exp=1", tx_o); end
    vectors++; if (tx_rts_n_o !== 1'b1) begin miscompares++; $display("FAIL flow_rts got=%b exp=1", tx_rts_n_o); end
    @(negedge tck); #1;
    tx_cts_n_i = 1'b1;
    t0 = tcount;
    t = 0;
    while (fstart.size() == 0 && t < 10) begin tck_wait(1); t++; end
    vectors++;
    if (fstart.size() == 0) begin
      miscompares++; $display("FAIL flow_start_latency got=none exp<=3");
    end else if (fstart[0] - t0 > 3 || fstart[0] <= t0) begin
      miscompares++; $display("FAIL flow_start_latency got=%0d exp<=3", fstart[0] - t0);
    end
    tck_wait(3);
    tx_cts_n_i = 1'b0;
    tck_wait(40);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++; $display("FAIL flow_drop_count got=%0d exp=1", frames.size());
    end else begin
      got = frames.pop_front();
      exp = model_frame(model_q.pop_front());
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL flow_frame1 got=%b exp=%b", got, exp); end
    end
    vectors++; if (tx_rts_n_o !== 1'b1) begin miscompares++; $display("FAIL flow_rts_pending got=%b exp=1", tx_rts_n_o); end
    tx_cts_n_i = 1'b1;
    wait_frames(1, 30);
    vectors++;
    if (frames.size() != 1 || model_q.size() != 1) begin
      miscompares++; $display("FAIL flow_resume_count got=%0d exp=1", frames.size());
    end else begin
      got = frames.pop_front();
      exp = model_frame(model_q.pop_front());
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL flow_frame2 got=%b exp=%b", got, exp); end
    end
    tck_wait(4);
  endtask

  task automatic test_half_duplex();
    bit          acc;
    logic [10:0] got, exp;
    clear_queues();
    cfg.mode = HALFDUPLEX;
    tx_enable_i = 1'b0;
    write_byte(8'($urandom), acc);
    tck_wait(20);
    vectors++; if (fstart.size() != 0) begin miscompares++; $display("FAIL hd_disabled got=%0d frames exp=0", fstart.size()); end
    vectors++; if (tx_rts_n_o !== 1'b0) begin miscompares++; $display("FAIL hd_rts got=%b exp=0", tx_rts_n_o); end
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL hd_line got=%b exp=1", tx_o); end
    tx_enable_i = 1'b1;
    wait_frames(1, 25);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++; $display("FAIL hd_enabled_count got=%0d exp=1", frames.size());
    end else begin
      got = frames.pop_front();
      exp = model_frame(model_q.pop_front());
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL hd_frame got=%b exp=%b", got, exp); end
    end
    tck_wait(3);
    tx_enable_i = 1'b0;
    cfg.mode = FULLDUPLEX;
  endtask

  task automatic test_flush();
    bit          acc;
    logic [10:0] got, exp;
    clear_queues();
    for (int i = 0; i < 4; i++) write_byte(8'($urandom), acc);
    wait_busy(10);
    tck_wait(4);
    cfg.flush_tx = 1'b1;
    tck_wait(20);
    cfg.flush_tx = 1'b0;
    tck_wait(20);
    vectors++;
    if (frames.size() != 1) begin
      miscompares++; $display("FAIL flush_count got=%0d exp=1", frames.size());
    end else begin
      got = frames.pop_front();
      exp = model_frame(model_q.pop_front());
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL flush_frame got=%b exp=%b", got, exp); end
    end
    model_q.delete();
    vectors++; if (tx_empty_o !== 1'b1) begin miscompares++; $display("FAIL flush_empty got=%b exp=1", tx_empty_o); end
    vectors++; if (irq.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL flush_irq_empty got=%b exp=1", irq.fifo_empty); end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    clear_queues();
    write_byte(8'h00, acc);
    write_byte(8'h3C, acc);
    write_byte(8'h81, acc);
    wait_busy(10);
    tck_wait(3);
    vectors++; if (tx_o !== 1'b0) begin miscompares++; $display("FAIL rst_pre_line got=%b exp=0", tx_o); end
    #5;
    rst_n = 1'b0;
    #1;
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL rst_line got=%b exp=1", tx_o); end
    vectors++; if (tx_busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", tx_busy_o); end
    vectors++; if (tx_empty_o !== 1'b1) begin miscompares++; $display("FAIL rst_empty got=%b exp=1", tx_empty_o); end
    tck_wait(2);
    rst_n = 1'b1;
    clear_queues();
    tck_wait(30);
    vectors++; if (fstart.size() != 0) begin miscompares++; $display("FAIL rst_no_frames got=%0d exp=0", fstart.size()); end
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("FAIL rst_idle_line got=%b exp=1", tx_o); end
  endtask

  task automatic test_random();
    bit          acc;
    logic [10:0] got, exp;
    int unsigned n, tries;
    clear_queues();
    n = 0;
    tries = 0;
    while (n < 12 && tries < 2000) begin
      write_byte(8'($urandom), acc);
      if (acc) n++;
      repeat ($urandom_range(0, 12)) @(negedge clk);
      tries++;
    end
    wait_frames(12, 12 * 11 + 60);
    vectors++;
    if (frames.size() != 12) begin
      miscompares++; $display("FAIL rand_count got=%0d exp=12", frames.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        got = frames.pop_front();
        exp = model_frame(model_q.pop_front());
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL rand_frame%0d got=%b exp=%b", i, got, exp); end
      end
    end
    tck_wait(4);
  endtask

  initial begin
    cfg.mode = FULLDUPLEX;
    cfg.flush_tx = 1'b0;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_flow_control();
    test_half_duplex();
    test_flush();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
